msg_scroller: RTL and testbench
===============================

Name: msg_scroller

Overview:
- Upstream of the anode/character drive stage; produces the 16-bit window `current_msg` (4 hex nibbles, digit 3 in [15:12]) that the anode drive multiplexes.
- Holds a writable 16x4 message buffer and a window pointer.
- Button presses scroll the window one character forward or backward, wrapping modulo 16.
- Replaces the fixed-message memory with a loadable, bidirectional, glitch-free scroller; optional hold-to-repeat.

Parameters:
- REPEAT_DLY, 2500000: clk cycles the button must stay held after the initial press before the first auto-repeat shift.
- REPEAT_PER, 1000000: clk cycles between subsequent auto-repeat shifts.
- CNT_W, 22: width of the hold counter. Must hold max(REPEAT_DLY, REPEAT_PER) - 1.

Ports:
- clk  in  1  display-domain clock
- reset  in  1  asynchronous, active-low reset
- button  in  1  debounced, synchronous scroll request (high = pressed)
- dir  in  1  scroll direction: 0 = forward (ptr+1), 1 = backward (ptr-1); sampled on each shift
- wr_en  in  1  buffer write strobe
- wr_addr  in  4  buffer write address
- wr_data  in  4  nibble to write
- current_msg  out  16  {mem[ptr], mem[ptr+1], mem[ptr+2], mem[ptr+3]}, indices mod 16, registered
- ptr  out  4  current window start index
- shift_pulse  out  1  one-cycle pulse, high in the cycle after each pointer move

Behaviour:
- Reset (reset=0, async):
  - mem[i] = i for i = 0..15
  - ptr = 0
  - current_msg = 16'h0123
  - shift_pulse = 0
  - btn_q = 0
  - FSM = IDLE
  - hold counter = 0
- Press: press = button & ~btn_q, with btn_q being button registered every cycle.
- Shift at edge E (FSM decides a shift):
  - ptr <= ptr + 1 (dir=0) or ptr - 1 (dir=1), 4-bit wrap: 15 -> 0 and 0 -> 15.
  - shift_pulse = 1 for exactly the cycle after E.
- current_msg refresh:
  - current_msg <= window(ptr, mem) on every edge, using the registered ptr and mem.
  - Any ptr change or buffer write is visible on current_msg exactly 1 cycle after it takes effect (2 edges after the press is sampled).
  - No intermediate or partial window ever appears.
- Write: on wr_en, mem[wr_addr] <= wr_data at that edge. A write and a shift in the same edge both take effect; the next refresh reflects both.
- FSM, states IDLE, HELD, REPEAT:
  - IDLE: on press -> shift, cnt = 0, go to HELD. Otherwise stay.
  - HELD: button=0 -> IDLE. Else cnt++. When cnt == REPEAT_DLY-1 (feature enabled) -> shift, cnt = 0, go to REPEAT.
  - REPEAT: button=0 -> IDLE. Else cnt++. When cnt == REPEAT_PER-1 -> shift, cnt = 0, stay in REPEAT.
  - A release followed by a press on consecutive cycles produces a fresh press from IDLE; there is no lost edge.
- Reset asserted mid-hold or mid-write aborts immediately to reset values; the buffer contents are lost.
- dir is sampled at each shift edge only; changing dir while held changes the direction of subsequent repeats.

Optional Feature:
- Macro: MSG_SCROLLER_AUTO_REPEAT_EN.
- Defined: HELD -> REPEAT transitions as above; holding the button scrolls continuously.
- Undefined:
  - HELD only waits for release; REPEAT is unreachable.
  - Exactly one shift per press regardless of hold duration.
  - REPEAT_DLY and REPEAT_PER are unused.

Decomposition:
- Shared package msg_pkg:
  - MSG_DEPTH = 16, CHAR_W = 4, WIN_CHARS = 4
  - FSM state typedef (IDLE, HELD, REPEAT)
  - DIR_FWD / DIR_BWD constants
  - Reset message (identity 0..F) constant
- One sub-module, press_repeat_gen: button edge detection, hold counter and FSM; outputs a shift strobe.
- The msg_scroller top keeps the buffer, pointer and window register.

Test Plan:
- Reset release, no input -> current_msg = 16'h0123, ptr = 0, shift_pulse = 0 for 20 cycles.
- Single press, dir=0, held 3 cycles -> ptr = 1 one cycle after the press is sampled, shift_pulse high exactly 1 cycle, current_msg = 16'h1234 one cycle later. With macro undefined, holding 100 cycles gives no further shift.
- From ptr=0, press with dir=1 -> ptr = 15, current_msg = 16'hF012. Then 13 forward presses -> ptr = 12, current_msg = 16'hCDEF (wrap correct).
- wr_en with wr_addr=2, wr_data=4'hA while ptr=0 -> current_msg = 16'h01A3 one cycle after the write. A write to addr 2 in the same edge as a forward shift -> current_msg = 16'h1A34.
- Macro defined, REPEAT_DLY=4, REPEAT_PER=2, button held 12 cycles -> shift_pulse count = 1 (press) + 1 (after 4 cycles) + 3 (every 2), ptr = 5. After release, no further pulses.
- Reset asserted while in REPEAT with ptr=7 and mem[0] = 4'hB -> outputs return immediately to 16'h0123 / ptr 0; FSM resumes from IDLE; a still-held button causes no shift until released and pressed again.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared types and constants for the message scroller: buffer geometry,
// repeat FSM states, scroll directions and the power-on message.
package msg_pkg;

    localparam int unsigned MSG_DEPTH = 16;
    localparam int unsigned CHAR_W    = 4;
    localparam int unsigned WIN_CHARS = 4;
    localparam int unsigned PTR_W     = $clog2(MSG_DEPTH);
    localparam int unsigned WIN_W     = CHAR_W * WIN_CHARS;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } rpt_state_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

    typedef logic [MSG_DEPTH-1:0][CHAR_W-1:0] msg_buf_t;

    // Identity message: entry i holds character i
    localparam msg_buf_t RESET_MSG = 64'hFEDC_BA98_7654_3210;

    // Window starting at p, first character in the top nibble, wrapping mod depth
    function automatic logic [WIN_W-1:0] window_of(input logic [PTR_W-1:0] p,
                                                   input msg_buf_t m);
        logic [WIN_W-1:0] w;
        logic [PTR_W-1:0] idx;
        w   = '0;
        idx = p;
        for (int unsigned k = 0; k < WIN_CHARS; k++) begin
            w   = {w[WIN_W-CHAR_W-1:0], m[idx]};
            idx = idx + PTR_W'(1);
        end
        return w;
    endfunction

endpackage

// File: rtl/press_repeat_gen.sv
// Button edge detection, hold counter and press/repeat FSM producing a shift strobe.
// Auto-repeat is compiled in only when MSG_SCROLLER_AUTO_REPEAT_EN is defined.
module press_repeat_gen
    import msg_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = 2500000,
    parameter int unsigned REPEAT_PER = 1000000,
    parameter int unsigned CNT_W      = 22
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_i,
    output logic shift_c_o
);

`ifdef MSG_SCROLLER_AUTO_REPEAT_EN
    localparam bit AUTO_RPT = 1'b1;
`else
    localparam bit AUTO_RPT = 1'b0;
`endif

    logic             btn_q;
    logic             arm_q;
    rpt_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;

    logic press_c;
    logic dly_hit_c;
    logic per_hit_c;

    // arm_q blocks a button that was already held when reset released
    assign press_c   = button_i & ~btn_q & arm_q;
    assign dly_hit_c = AUTO_RPT && (cnt_q == CNT_W'(REPEAT_DLY - 1));
    assign per_hit_c = (cnt_q == CNT_W'(REPEAT_PER - 1));

    assign shift_c_o = ((state_q == IDLE)   && press_c)
                    || ((state_q == HELD)   && button_i && dly_hit_c)
                    || ((state_q == REPEAT) && button_i && per_hit_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q   <= 1'b0;
            arm_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            btn_q <= button_i;
            arm_q <= arm_q | ~button_i;
            case (state_q)
                IDLE: begin
                    if (press_c) begin
                        cnt_q   <= '0;
                        state_q <= HELD;
                    end
                end
                HELD: begin
                    if (!button_i) begin
                        state_q <= IDLE;
                    end else if (dly_hit_c) begin
                        cnt_q   <= '0;
                        state_q <= REPEAT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!button_i) begin
                        state_q <= IDLE;
                    end else if (per_hit_c) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/msg_scroller.sv
// Loadable 16-character message buffer with a bidirectional 4-character window.
// Hold-to-repeat scrolling is enabled by defining MSG_SCROLLER_AUTO_REPEAT_EN.
module msg_scroller
    import msg_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = 2500000,
    parameter int unsigned REPEAT_PER = 1000000,
    parameter int unsigned CNT_W      = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button,
    input  logic              dir,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    output logic [WIN_W-1:0]  current_msg,
    output logic [PTR_W-1:0]  ptr,
    output logic              shift_pulse
);

    msg_buf_t         mem_q, mem_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [WIN_W-1:0] msg_q;
    logic             pulse_q;
    logic             shift_c;

    press_repeat_gen #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER),
        .CNT_W      (CNT_W)
    ) u_press (
        .clk       (clk),
        .rst_n     (reset),
        .button_i  (button),
        .shift_c_o (shift_c)
    );

    // Pointer move and buffer write are independent and may coincide
    always_comb begin
        ptr_d = ptr_q;
        mem_d = mem_q;
        if (shift_c) begin
            case (dir)
                DIR_FWD: ptr_d = ptr_q + PTR_W'(1);
                DIR_BWD: ptr_d = ptr_q - PTR_W'(1);
                default: ptr_d = ptr_q;
            endcase
        end
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Window is rebuilt from registered state only, so it never shows a partial update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q   <= RESET_MSG;
            ptr_q   <= '0;
            msg_q   <= window_of(PTR_W'(0), RESET_MSG);
            pulse_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            msg_q   <= window_of(ptr_q, mem_q);
            pulse_q <= shift_c;
        end
    end

    assign current_msg = msg_q;
    assign ptr         = ptr_q;
    assign shift_pulse = pulse_q;

endmodule

// File: tb/tb_msg_scroller.sv
// Self-checking bench for msg_scroller: vector table plus directed multi-cycle
// sequences, expected outputs queued at drive time and compared after each edge.
module tb_msg_scroller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        button = 1'b0;
    logic        dir = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [3:0]  wr_data = 4'd0;
    logic [15:0] current_msg;
    logic [3:0]  ptr;
    logic        shift_pulse;

    msg_scroller #(
        .REPEAT_DLY (4),
        .REPEAT_PER (2),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button      (button),
        .dir         (dir),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .current_msg (current_msg),
        .ptr         (ptr),
        .shift_pulse (shift_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ptr;
        logic [15:0] msg;
        logic        pulse;
        string       tag;
    } exp_t;

    typedef struct {
        logic        btn;
        logic        dir;
        logic        we;
        logic [3:0]  wa;
        logic [3:0]  wd;
        logic [3:0]  eptr;
        logic [15:0] emsg;
        logic        epulse;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    exp_t        e_cur;
    int          n_chk = 0;
    int          n_fail = 0;
    int          pulse_cnt = 0;
    logic [3:0]  mem_m [16];
    logic [3:0]  ptr_m = 4'd0;

    function automatic logic [15:0] win_m(input logic [3:0] p);
        logic [15:0] w;
        logic [3:0]  a;
        w = 16'h0;
        a = p;
        for (int k = 0; k < 4; k++) begin
            w[15-4*k -: 4] = mem_m[a];
            a = a + 4'd1;
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: one queued expectation per edge, compared just after it
    always @(posedge clk) begin
        #1;
        if (shift_pulse === 1'b1) pulse_cnt++;
        if (sb.size() > 0) begin
            e_cur = sb.pop_front();
            check({e_cur.tag, " ptr"},   {12'h0, ptr},         {12'h0, e_cur.ptr});
            check({e_cur.tag, " msg"},   current_msg,          e_cur.msg);
            check({e_cur.tag, " pulse"}, {15'h0, shift_pulse}, {15'h0, e_cur.pulse});
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = 4'(i);
        ptr_m = 4'd0;
    endtask

    // Drive one cycle; sh says whether this edge must move the pointer
    task automatic step(input logic btn, input logic d, input logic we,
                        input logic [3:0] wa, input logic [3:0] wd,
                        input logic sh, input string tag);
        exp_t e;
        @(negedge clk);
        button = btn; dir = d; wr_en = we; wr_addr = wa; wr_data = wd;
        e.msg   = win_m(ptr_m);
        e.pulse = sh;
        if (sh) ptr_m = d ? ptr_m - 4'd1 : ptr_m + 4'd1;
        if (we) mem_m[wa] = wd;
        e.ptr = ptr_m;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic press_fwd(input string tag);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, tag);
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, tag);
    endtask

    task automatic flush();
        @(posedge clk);
        #2;
        check("sb drained", 16'(sb.size()), 16'd0);
    endtask

    task automatic add_vec(input logic b, input logic d, input logic [3:0] ep,
                           input logic [15:0] em, input logic epl);
        vec_t v;
        v.btn = b; v.dir = d; v.we = 1'b0; v.wa = 4'd0; v.wd = 4'd0;
        v.eptr = ep; v.emsg = em; v.epulse = epl;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         p0;
        logic [3:0] n4;
        logic [3:0] start;
        exp_t       e;

        add_vec(1'b1, 1'b0, 4'd1,  16'h0123, 1'b1);
        add_vec(1'b1, 1'b0, 4'd1,  16'h1234, 1'b0);
        add_vec(1'b1, 1'b0, 4'd1,  16'h1234, 1'b0);
        add_vec(1'b0, 1'b0, 4'd1,  16'h1234, 1'b0);
        add_vec(1'b1, 1'b1, 4'd0,  16'h1234, 1'b1);
        add_vec(1'b0, 1'b1, 4'd0,  16'h0123, 1'b0);
        add_vec(1'b1, 1'b1, 4'd15, 16'h0123, 1'b1);
        add_vec(1'b0, 1'b0, 4'd15, 16'hF012, 1'b0);

        model_reset();
        @(negedge clk);
        check("in reset msg",   current_msg,          16'h0123);
        check("in reset ptr",   {12'h0, ptr},         16'h0);
        check("in reset pulse", {15'h0, shift_pulse}, 16'h0);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "idle");

        foreach (vecs[i]) begin
            @(negedge clk);
            button = vecs[i].btn; dir = vecs[i].dir; wr_en = vecs[i].we;
            wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            e.ptr = vecs[i].eptr; e.msg = vecs[i].emsg; e.pulse = vecs[i].epulse;
            e.tag = $sformatf("vec%0d", i);
            sb.push_back(e);
            ptr_m = vecs[i].eptr;
            if (vecs[i].we) mem_m[vecs[i].wa] = vecs[i].wd;
        end

        for (int i = 0; i < 13; i++) press_fwd("wrap");
        flush();
        check("wrap ptr", {12'h0, ptr}, 16'd12);
        check("wrap msg", current_msg,  16'hCDEF);

        for (int i = 0; i < 4; i++) press_fwd("to0");
        step(1'b0, 1'b0, 1'b1, 4'd2, 4'hA, 1'b0, "wr");
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "wr");
        flush();
        check("write msg", current_msg, 16'h01A3);
        step(1'b0, 1'b0, 1'b1, 4'd2, 4'h2, 1'b0, "wr restore");
        step(1'b1, 1'b0, 1'b1, 4'd2, 4'hA, 1'b1, "wr+shift");
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "wr+shift");
        flush();
        check("wr+shift msg", current_msg,  16'h1A34);
        check("wr+shift ptr", {12'h0, ptr}, 16'd1);

        p0 = pulse_cnt;
`ifdef MSG_SCROLLER_AUTO_REPEAT_EN
        for (int k = 0; k < 12; k++)
            step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0,
                 (k == 0 || k == 4 || k == 6 || k == 8 || k == 10), "repeat");
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "released");
        flush();
        check("repeat pulses", 16'(pulse_cnt - p0), 16'd5);
        check("repeat ptr",    {12'h0, ptr},        16'd6);
        start = 4'd4;
`else
        for (int k = 0; k < 100; k++)
            step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, (k == 0), "hold");
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "released");
        flush();
        check("hold pulses", 16'(pulse_cnt - p0), 16'd1);
        check("hold ptr",    {12'h0, ptr},        16'd2);
        start = 4'd6;
`endif

        step(1'b0, 1'b0, 1'b1, 4'd0, 4'hB, 1'b0, "wr mem0");
        n4 = start - ptr_m;
        for (int i = 0; i < int'(n4); i++) press_fwd("seek");
`ifdef MSG_SCROLLER_AUTO_REPEAT_EN
        for (int k = 0; k < 7; k++)
            step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, (k == 0 || k == 4 || k == 6), "pre-reset");
`else
        for (int k = 0; k < 7; k++)
            step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, (k == 0), "pre-reset");
`endif
        flush();
        check("pre-reset ptr", {12'h0, ptr}, 16'd7);

        reset = 1'b0;
        #1;
        check("mid reset msg",   current_msg,          16'h0123);
        check("mid reset ptr",   {12'h0, ptr},         16'h0);
        check("mid reset pulse", {15'h0, shift_pulse}, 16'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        p0 = pulse_cnt;
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "held thru reset");
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "post-reset");
        flush();
        check("held thru reset pulses", 16'(pulse_cnt - p0), 16'd0);
        press_fwd("fresh press");
        flush();
        check("fresh press ptr", {12'h0, ptr}, 16'd1);
        check("fresh press msg", current_msg,  16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
